// File: rtl/psum_requantizer.sv
// psum_requantizer: 2-stage valid/ready narrowing of 2*DW partial sums with shift, round, saturate and ReLU
module psum_requantizer #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH) + 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_cfg_we,
    input  logic [SHIFT_WIDTH-1:0]  i_cfg_shift,
    input  logic                    i_cfg_round,
    input  logic                    i_cfg_sat,
    input  logic                    i_cfg_relu,
    output logic                    o_cfg_err,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [2*DATA_WIDTH-1:0] i_in_data,
    input  logic                    i_in_last,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [DATA_WIDTH-1:0]   o_out_data,
    output logic                    o_out_last,
    output logic                    o_busy,
    output logic [CNT_WIDTH-1:0]    o_sat_count
);
    localparam int IW = 2 * DATA_WIDTH;
    localparam int TW = IW + 1;

    logic [SHIFT_WIDTH-1:0] r_shift;
    logic                   r_round, r_sat, r_relu, r_cfg_err;
    logic                   r_s1_valid, r_s1_last;
    logic [TW-1:0]          r_s1_t;
    logic                   r_out_valid, r_out_last, r_out_sat;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic [CNT_WIDTH-1:0]   r_sat_count;

    logic                   w_en, w_acc, w_cfg_ok, w_ovf;
    logic [SHIFT_WIDTH-1:0] w_sh;
    logic signed [TW-1:0]   w_bias, w_sum, w_t;
    logic [IW-DATA_WIDTH+1:0] w_top;
    logic [DATA_WIDTH-1:0]  w_q, w_res;

    assign w_en       = !r_out_valid || i_out_ready;
    assign w_acc      = i_in_valid && w_en;
    assign o_in_ready = w_en;
    assign o_busy     = r_s1_valid || r_out_valid;
    assign w_cfg_ok   = i_cfg_we && !o_busy && !w_acc;

    // Stage 1 arithmetic: the extra top bit keeps the rounding add from overflowing
    assign w_sh   = (r_shift > SHIFT_WIDTH'(DATA_WIDTH)) ? SHIFT_WIDTH'(DATA_WIDTH) : r_shift;
    assign w_bias = (r_round && w_sh != '0) ? (TW'(1) << (w_sh - 1'b1)) : '0;
    assign w_sum  = {i_in_data[IW-1], i_in_data} + w_bias;
    assign w_t    = w_sum >>> w_sh;

    // Stage 2 arithmetic: any disagreement among bits above the output sign bit means overflow
    assign w_top = r_s1_t[TW-1:DATA_WIDTH-1];
    assign w_ovf = !(&w_top) && (|w_top);
    assign w_q   = (r_sat && w_ovf) ? {r_s1_t[TW-1], {(DATA_WIDTH-1){~r_s1_t[TW-1]}}}
                                    : r_s1_t[DATA_WIDTH-1:0];
    assign w_res = (r_relu && w_q[DATA_WIDTH-1]) ? '0 : w_q;

    assign o_cfg_err   = r_cfg_err;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_sat_count = r_sat_count;

    // Config registers load only while the pipeline is empty and idle; otherwise flag the rejection
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift   <= '0;
            r_round   <= 1'b0;
            r_sat     <= 1'b1;
            r_relu    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= i_cfg_we && !w_cfg_ok;
            if (w_cfg_ok) begin
                r_shift <= i_cfg_shift;
                r_round <= i_cfg_round;
                r_sat   <= i_cfg_sat;
                r_relu  <= i_cfg_relu;
            end
        end
    end

    // Stage 1: capture shifted/rounded value whenever the pipeline advances
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_t     <= '0;
        end else if (w_en) begin
            r_s1_valid <= i_in_valid;
            r_s1_last  <= i_in_last;
            r_s1_t     <= w_t;
        end
    end

    // Stage 2: saturate or wrap, apply ReLU, remember whether the item saturated
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_s1_valid;
            r_out_last  <= r_s1_last;
            r_out_data  <= w_res;
            r_out_sat   <= r_s1_valid && r_sat && w_ovf;
        end
    end

    // Saturation counter advances once per delivered saturated item and sticks at all-ones
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_sat_count <= '0;
        else if (r_out_valid && i_out_ready && r_out_sat && !(&r_sat_count))
            r_sat_count <= r_sat_count + 1'b1;
    end
endmodule

// File: tb/tb_psum_requantizer.sv
// tb_psum_requantizer: scoreboard bench with a plain-arithmetic reference model
module tb_psum_requantizer;
    localparam int DW = 16;
    localparam int SW = 5;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_cfg_we = 1'b0;
    logic [SW-1:0] i_cfg_shift = '0;
    logic          i_cfg_round = 1'b0, i_cfg_sat = 1'b1, i_cfg_relu = 1'b0;
    logic          o_cfg_err;
    logic          i_in_valid = 1'b0;
    logic          o_in_ready;
    logic [2*DW-1:0] i_in_data = '0;
    logic          i_in_last = 1'b0;
    logic          o_out_valid;
    logic          i_out_ready = 1'b1;
    logic [DW-1:0] o_out_data;
    logic          o_out_last, o_busy;
    logic [CW-1:0] o_sat_count;

    psum_requantizer #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_cfg_we(i_cfg_we), .i_cfg_shift(i_cfg_shift),
        .i_cfg_round(i_cfg_round), .i_cfg_sat(i_cfg_sat), .i_cfg_relu(i_cfg_relu),
        .o_cfg_err(o_cfg_err), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_data(i_in_data), .i_in_last(i_in_last), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_out_data(o_out_data), .o_out_last(o_out_last),
        .o_busy(o_busy), .o_sat_count(o_sat_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] d; bit l; bit s; } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0, exp_cnt = 0;
    int m_shift = 0;
    bit m_round = 0, m_sat = 1, m_relu = 0;
    bit rand_rdy = 0, man_rdy = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: real-valued floor of (x + bias) / 2^s, then clamp or modulo, then ReLU
    function automatic logic [DW-1:0] model(input logic [31:0] din, output bit satf);
        longint v, d, r, t, q;
        logic [63:0] qq;
        int e;
        v = longint'($signed(din));
        e = (m_shift > DW) ? DW : m_shift;
        if (m_round && e > 0) v = v + (longint'(1) << (e - 1));
        d = longint'(1) << e;
        r = v % d;
        if (r < 0) r = r + d;
        t = (v - r) / d;
        satf = 0;
        if (m_sat) begin
            if (t > 32767) begin q = 32767; satf = 1; end
            else if (t < -32768) begin q = -32768; satf = 1; end
            else q = t;
        end else begin
            q = t & 64'hFFFF;
            if (q > 32767) q = q - 65536;
        end
        if (m_relu && q < 0) q = 0;
        qq = q;
        return qq[DW-1:0];
    endfunction

    always @(posedge clk) begin
        #2;
        i_out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : man_rdy;
    end

    // Monitor: pop and compare on every output handshake
    always @(negedge clk) begin
        exp_t e;
        if (i_reset) begin
            sb.delete();
            exp_cnt = 0;
        end else if (o_out_valid && i_out_ready) begin
            chk("sat_count", o_sat_count, exp_cnt);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got %0h expected none", o_out_data);
            end else begin
                e = sb.pop_front();
                chk("out_data", o_out_data, e.d);
                chk("out_last", o_out_last, e.l);
                if (e.s && exp_cnt < CMAX) exp_cnt++;
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit last);
        exp_t e;
        int n = 0;
        bit ok = 1;
        i_in_data = d; i_in_last = last; i_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (o_in_ready) break;
            if (++n > 200) begin
                checks++; errors++; ok = 0;
                $display("FAIL in_ready_timeout: got 0 expected 1");
                break;
            end
        end
        if (ok) begin
            e.d = model(d, e.s);
            e.l = last;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        i_in_valid = 1'b0; i_in_last = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        forever begin
            @(negedge clk);
            if (sb.size() == 0 && !o_out_valid) break;
            if (++n > 500) begin
                checks++; errors++;
                $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic cfg(input int sh, input bit rnd, input bit st, input bit rl);
        i_cfg_we = 1'b1; i_cfg_shift = SW'(sh);
        i_cfg_round = rnd; i_cfg_sat = st; i_cfg_relu = rl;
        @(posedge clk); #1;
        i_cfg_we = 1'b0;
        chk("cfg_err_idle", o_cfg_err, 0);
        m_shift = sh; m_round = rnd; m_sat = st; m_relu = rl;
    endtask

    function automatic logic [31:0] rnd_data();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 2))
            0: return x;
            1: return {{12{x[19]}}, x[19:0]};
            default: return {{8{x[23]}}, x[23:0]};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_out_data", o_out_data, 0);
        chk("rst_out_last", o_out_last, 0);
        chk("rst_sat_count", o_sat_count, 0);
        chk("rst_cfg_err", o_cfg_err, 0);
        chk("rst_busy", o_busy, 0);
        i_reset = 1'b0;
        @(posedge clk); #1;

        // T1: basic shift with latency check
        cfg(4, 0, 1, 0);
        send(32'h0000_1238, 0);
        @(negedge clk); chk("lat_c1_valid", o_out_valid, 0);
        @(negedge clk); chk("lat_c2_valid", o_out_valid, 1);
        drain();
        chk("t1_sat_count", o_sat_count, 0);

        // T2: rounding vs truncation
        cfg(4, 1, 1, 0);
        send(32'h0000_0018, 0);
        send(32'hFFFF_FFE8, 0);
        drain();
        cfg(4, 0, 1, 0);
        send(32'h0000_0018, 0);
        drain();

        // T3: saturation, ReLU on saturated negative, wrap
        send(32'h0100_0000, 0);
        drain();
        cfg(0, 0, 1, 0);
        send(32'hF000_0000, 0);
        drain();
        cfg(0, 0, 1, 1);
        send(32'hF000_0000, 0);
        drain();
        cfg(4, 0, 0, 0);
        send(32'h0100_0000, 0);
        drain();
        chk("t3_sat_count", o_sat_count, exp_cnt);

        // T4: backpressure stall
        cfg(0, 0, 1, 0);
        fork
            begin
                for (int i = 1; i <= 5; i++) send(32'(i), i == 5);
            end
            begin
                int n = 0;
                forever begin
                    @(negedge clk);
                    if (o_out_valid) break;
                    if (++n > 50) begin
                        checks++; errors++;
                        $display("FAIL t4_valid_timeout: got 0 expected 1");
                        break;
                    end
                end
                @(posedge clk); #1;
                man_rdy = 0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("t4_stall_in_ready", o_in_ready, 0);
                    chk("t4_stall_valid", o_out_valid, 1);
                end
                @(posedge clk); #1;
                man_rdy = 1;
            end
        join
        drain();

        // T5: rejected config while busy, and when colliding with an input handshake
        cfg(4, 0, 1, 0);
        send(32'h0000_0100, 0);
        i_cfg_we = 1'b1; i_cfg_shift = '0;
        @(posedge clk); #1;
        i_cfg_we = 1'b0;
        chk("t5_cfg_err_busy", o_cfg_err, 1);
        @(posedge clk); #1;
        chk("t5_cfg_err_pulse", o_cfg_err, 0);
        send(32'h0000_0200, 0);
        drain();
        i_cfg_we = 1'b1; i_cfg_shift = '0;
        send(32'h0000_0300, 0);
        i_cfg_we = 1'b0;
        chk("t5_cfg_err_hs", o_cfg_err, 1);
        send(32'h0000_0400, 0);
        drain();

        // Reset with two items in flight
        man_rdy = 0;
        send(32'h0000_0500, 0);
        send(32'h0000_0600, 1);
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        m_shift = 0; m_round = 0; m_sat = 1; m_relu = 0;
        chk("mid_rst_out_valid", o_out_valid, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_sat_count", o_sat_count, 0);
        man_rdy = 1;
        send(32'h0001_0000, 0);
        drain();
        chk("mid_rst_default_cnt", o_sat_count, 1);

        // Randomized configs and data with random downstream readiness
        rand_rdy = 1;
        for (int r = 0; r < 8; r++) begin
            cfg($urandom_range(0, 31), 1'($urandom), 1'($urandom), 1'($urandom));
            for (int i = 0; i < 30; i++) send(rnd_data(), 1'($urandom));
            drain();
        end

        // Drive the counter into its ceiling
        cfg(0, 0, 1, 0);
        for (int i = 0; i < 20; i++) send(32'h7FFF_0000, 0);
        drain();
        chk("sat_count_final", o_sat_count, exp_cnt);
        chk("sat_count_stuck", o_sat_count, CMAX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
